// File: rtl/tis_prog_loader.sv
// Byte-stream program loader for the core complex: parses SYNC/length/word/checksum
// frames, writes prog[] and pLength[], and holds the cores in reset until an image verifies.
module tis_prog_loader #(
  parameter int         NUM_CORES = 12,
  parameter int         MAX_INSTR = 15,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prog_we,
  output logic [7:0]  prog_addr,
  output logic [15:0] prog_wdata,
  output logic        len_we,
  output logic [3:0]  len_addr,
  output logic [3:0]  len_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int              WORDS     = NUM_CORES * MAX_INSTR;
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      LAST_ADDR = 8'(WORDS - 1);
  localparam logic [3:0]      LAST_CORE = 4'(NUM_CORES - 1);
  localparam logic [7:0]      MAX_LEN   = 8'(MAX_INSTR);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t         state_r, state_s;
  logic [3:0]     idx_r, idx_s;
  logic [7:0]     addr_r, addr_s;
  logic [7:0]     hi_r, hi_s;
  logic [7:0]     csum_r, csum_s;
  logic [TW-1:0]  tmo_r, tmo_s;
  logic           prog_we_r, prog_we_s;
  logic [7:0]     prog_addr_r, prog_addr_s;
  logic [15:0]    prog_wdata_r, prog_wdata_s;
  logic           len_we_r, len_we_s;
  logic [3:0]     len_addr_r, len_addr_s;
  logic [3:0]     len_wdata_r, len_wdata_s;
  logic           core_rst_r, core_rst_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           err_r, err_s;
  logic           take_s;

  // The loader never stalls the source, so every valid byte is a transfer.
  assign in_ready = 1'b1;
  assign take_s   = in_valid & in_ready;

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    addr_s       = addr_r;
    hi_s         = hi_r;
    csum_s       = csum_r;
    tmo_s        = tmo_r;
    prog_we_s    = 1'b0;
    prog_addr_s  = prog_addr_r;
    prog_wdata_s = prog_wdata_r;
    len_we_s     = 1'b0;
    len_addr_s   = len_addr_r;
    len_wdata_s  = len_wdata_r;
    core_rst_s   = core_rst_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    err_s        = err_r;

    if (state_r == ST_IDLE) begin
      tmo_s = TW'(0);
      if (take_s && (in_data == SYNC)) begin
        state_s    = ST_LEN;
        core_rst_s = 1'b1;
        busy_s     = 1'b1;
        err_s      = 1'b0;
        csum_s     = 8'h00;
        idx_s      = 4'd0;
        addr_s     = 8'd0;
      end else begin
        state_s = ST_IDLE;
      end
    end else if (!take_s) begin
      // Idle gap inside a frame; abandon the frame once it lasts TIMEOUT cycles.
      if (tmo_r == TMO_LAST) begin
        err_s   = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
        tmo_s   = TW'(0);
      end else begin
        tmo_s = tmo_r + TW'(1);
      end
    end else begin
      tmo_s  = TW'(0);
      csum_s = csum_step(csum_r, in_data);
      case (state_r)
        ST_LEN: begin
          if (in_data > MAX_LEN) begin
            err_s   = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end else begin
            len_we_s    = 1'b1;
            len_addr_s  = idx_r;
            len_wdata_s = in_data[3:0];
            idx_s       = idx_r + 4'd1;
            if (idx_r == LAST_CORE) begin
              state_s = ST_HI;
            end else begin
              state_s = ST_LEN;
            end
          end
        end
        ST_HI: begin
          hi_s    = in_data;
          state_s = ST_LO;
        end
        ST_LO: begin
          prog_we_s    = 1'b1;
          prog_addr_s  = addr_r;
          prog_wdata_s = {hi_r, in_data};
          addr_s       = addr_r + 8'd1;
          if (addr_r == LAST_ADDR) begin
            state_s = ST_CSUM;
          end else begin
            state_s = ST_HI;
          end
        end
        ST_CSUM: begin
          // The accumulator excludes the checksum byte itself.
          if (in_data == csum_r) begin
            done_s     = 1'b1;
            core_rst_s = 1'b0;
          end else begin
            err_s = 1'b1;
          end
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
        default: begin
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      addr_r       <= 8'd0;
      hi_r         <= 8'h00;
      csum_r       <= 8'h00;
      tmo_r        <= TW'(0);
      prog_we_r    <= 1'b0;
      prog_addr_r  <= 8'd0;
      prog_wdata_r <= 16'h0000;
      len_we_r     <= 1'b0;
      len_addr_r   <= 4'd0;
      len_wdata_r  <= 4'd0;
      core_rst_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      addr_r       <= addr_s;
      hi_r         <= hi_s;
      csum_r       <= csum_s;
      tmo_r        <= tmo_s;
      prog_we_r    <= prog_we_s;
      prog_addr_r  <= prog_addr_s;
      prog_wdata_r <= prog_wdata_s;
      len_we_r     <= len_we_s;
      len_addr_r   <= len_addr_s;
      len_wdata_r  <= len_wdata_s;
      core_rst_r   <= core_rst_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
    end
  end

  assign prog_we    = prog_we_r;
  assign prog_addr  = prog_addr_r;
  assign prog_wdata = prog_wdata_r;
  assign len_we     = len_we_r;
  assign len_addr   = len_addr_r;
  assign len_wdata  = len_wdata_r;
  assign core_rst   = core_rst_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule
